// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache with a line-refill controller behind the fetch stage.
// Lookups are combinational in IDLE; misses refill the whole line word 0 first via req/ack.
module icache_refill_ctrl #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              inv_all,
  output logic [31:0]       instruction,
  output logic              hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(WORDS_PER_LINE);
  localparam int OB = CW + 2;
  localparam int IB = $clog2(LINES);
  localparam int LW = ADDR_W - OB;
  localparam int TW = LW - IB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    INSTALL = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [LINES-1:0] valid;
  logic [TW-1:0]   tag_mem  [LINES];
  logic [31:0]     data_mem [LINES*WORDS_PER_LINE];
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   fill_line;
  logic            killed;

  logic [CW-1:0]   off;
  logic [IB-1:0]   idx;
  logic [TW-1:0]   pc_tag;
  logic [IB-1:0]   fill_idx;
  logic [TW-1:0]   fill_tag;
  logic            lookup_hit;
  logic            start_fill;
  logic            word_ack;
  logic            install;
  logic            unused_pc_bits;

  assign off            = pc[OB-1:2];
  assign idx            = pc[OB+IB-1:OB];
  assign pc_tag         = pc[ADDR_W-1:OB+IB];
  assign fill_idx       = fill_line[IB-1:0];
  assign fill_tag       = fill_line[LW-1:IB];
  assign lookup_hit     = valid[idx] && (tag_mem[idx] == pc_tag);
  assign unused_pc_bits = ^pc[1:0];

  assign mem_addr    = {fill_line, cnt, 2'b00};
  assign instruction = hit ? data_mem[{idx, off}] : 32'h0;

  // State register; async reset drops mem_req immediately since it decodes from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    hit        = 1'b0;
    mem_req    = 1'b0;
    start_fill = 1'b0;
    word_ack   = 1'b0;
    install    = 1'b0;
    case (state)
      IDLE: begin
        hit = lookup_hit;
        if (!lookup_hit) begin
          start_fill = 1'b1;
          state_next = FILL;
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          word_ack = 1'b1;
          if (cnt == CW'(WORDS_PER_LINE - 1)) begin
            state_next = INSTALL;
          end else begin
            state_next = FILL;
          end
        end else begin
          state_next = FILL;
        end
      end
      INSTALL: begin
        install    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Refill bookkeeping: captured line, word counter, and the invalidated-mid-refill flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_line <= '0;
      cnt       <= '0;
      killed    <= 1'b0;
    end else begin
      if (start_fill) begin
        fill_line <= pc[ADDR_W-1:OB];
        cnt       <= '0;
        killed    <= 1'b0;
      end else begin
        if (word_ack) begin
          cnt <= cnt + CW'(1);
        end
        if (inv_all) begin
          killed <= 1'b1;
        end
      end
    end
  end

  // Valid bits; invalidate beats a same-edge install.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (inv_all) begin
      valid <= '0;
    end else if (install && !killed) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (word_ack) begin
      data_mem[{fill_idx, cnt}] <= mem_rdata;
    end
    if (install) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: vector table, directed refill corner cases and a
// randomized run checked against a line-level cache model.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        inv_all = 1'b0;
  logic [31:0] instruction;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int errors = 0;
  int checks = 0;

  logic        mv [16];
  logic [31:0] mt [16];

  icache_refill_ctrl #(.LINES(16), .WORDS_PER_LINE(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inv_all(inv_all),
    .instruction(instruction), .hit(hit), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic        ehit;
    logic [31:0] einstr;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs [16];

  // Contents of backing memory: a fixed function of the word address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (32'h11 + (a >> 2)) ^ ((a >> 8) << 20);
  endfunction

  function automatic vec_t mk(input logic [31:0] p, input logic a, input logic h,
                              input logic [31:0] i, input logic r, input logic [31:0] ad);
    vec_t v;
    v.pc = p; v.ack = a; v.ehit = h; v.einstr = i; v.ereq = r; v.eaddr = ad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      mt[i] = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pc = 32'h0; inv_all = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hit", {31'h0, hit}, 32'h0);
    chk("reset req", {31'h0, mem_req}, 32'h0);
    chk("reset addr", mem_addr, 32'h0);
    chk("reset instr", instruction, 32'h0);
    rst_n = 1'b1;
    clear_model();
  endtask

  // One fetch at p; on a predicted miss, services the refill and checks every cycle of it.
  // ack_mode: 0 zero-wait, 1 ack every 3rd cycle, 2 random. inv_at: refill cycle to pulse
  // inv_all (99 = the install cycle, -1 = never).
  task automatic access(input logic [31:0] p, input logic inv, input int ack_mode,
                        input logic use_mid, input logic [31:0] mid_pc, input int inv_at);
    int          li;
    logic [31:0] tg;
    logic [31:0] base;
    logic        eh;
    logic        killed;
    logic        a;
    int          k;
    int          cyc;
    li   = int'((p / 16) % 16);
    tg   = p / 256;
    base = (p / 16) * 16;
    eh   = mv[li] && (mt[li] == tg);
    pc = p; inv_all = inv; mem_ack = 1'b0;
    @(negedge clk);
    chk("lookup hit", {31'h0, hit}, {31'h0, eh});
    chk("lookup instr", instruction, eh ? mem_val(p & ~32'h3) : 32'h0);
    chk("lookup req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    inv_all = 1'b0;
    if (inv) clear_model();
    if (eh) return;
    killed = 1'b0; k = 0; cyc = 0;
    while (k < 4) begin
      case (ack_mode)
        0:       a = 1'b1;
        1:       a = ((cyc % 3) == 2);
        default: a = 1'($urandom_range(0, 1));
      endcase
      mem_ack   = a;
      mem_rdata = mem_val(base + 32'(4 * k));
      if (use_mid && cyc == 1) pc = mid_pc;
      inv_all = (cyc == inv_at);
      @(negedge clk);
      chk("fill req", {31'h0, mem_req}, 32'h1);
      chk("fill addr", mem_addr, base + 32'(4 * k));
      chk("fill hit", {31'h0, hit}, 32'h0);
      @(posedge clk); #1;
      if (inv_all) begin
        killed = 1'b1;
        clear_model();
      end
      if (a) k++;
      cyc++;
      if (cyc > 200) begin
        chk("fill timeout", 32'h1, 32'h0);
        break;
      end
    end
    mem_ack = 1'b0;
    inv_all = (inv_at == 99);
    @(negedge clk);
    chk("install req", {31'h0, mem_req}, 32'h0);
    chk("install hit", {31'h0, hit}, 32'h0);
    @(posedge clk); #1;
    if (inv_all) begin
      killed = 1'b1;
      clear_model();
    end
    inv_all = 1'b0;
    if (!killed) begin
      mv[li] = 1'b1;
      mt[li] = tg;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rp;
    logic [31:0] rm;

    // Cold fill of line 0, hits inside it, then a conflicting tag on the same index.
    vecs[0]  = mk(32'h0,   1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vecs[1]  = mk(32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    vecs[2]  = mk(32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 32'h4);
    vecs[3]  = mk(32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 32'h8);
    vecs[4]  = mk(32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 32'hC);
    vecs[5]  = mk(32'h0,   1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vecs[6]  = mk(32'h0,   1'b0, 1'b1, 32'h11, 1'b0, 32'h0);
    vecs[7]  = mk(32'h8,   1'b0, 1'b1, 32'h13, 1'b0, 32'h0);
    vecs[8]  = mk(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vecs[9]  = mk(32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100);
    vecs[10] = mk(32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104);
    vecs[11] = mk(32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h108);
    vecs[12] = mk(32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10C);
    vecs[13] = mk(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vecs[14] = mk(32'h104, 1'b0, 1'b1, 32'h00100052, 1'b0, 32'h0);
    vecs[15] = mk(32'h0,   1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      pc = vecs[i].pc;
      mem_ack = vecs[i].ack;
      mem_rdata = mem_val(vecs[i].eaddr);
      @(negedge clk);
      chk($sformatf("vec%0d hit", i), {31'h0, hit}, {31'h0, vecs[i].ehit});
      chk($sformatf("vec%0d instr", i), instruction, vecs[i].einstr);
      chk($sformatf("vec%0d req", i), {31'h0, mem_req}, {31'h0, vecs[i].ereq});
      if (vecs[i].ereq) chk($sformatf("vec%0d addr", i), mem_addr, vecs[i].eaddr);
      @(posedge clk); #1;
    end

    // Wait-state memory, then immediate hit after install.
    do_reset();
    access(32'h0, 1'b0, 1, 1'b0, 32'h0, -1);
    access(32'h0, 1'b0, 0, 1'b0, 32'h0, -1);
    access(32'hC, 1'b0, 0, 1'b0, 32'h0, -1);

    // pc moves mid-refill: captured line still installs, new pc then misses.
    do_reset();
    access(32'h0, 1'b0, 0, 1'b1, 32'h40, -1);
    access(32'h40, 1'b0, 0, 1'b0, 32'h0, -1);
    access(32'h4, 1'b0, 0, 1'b0, 32'h0, -1);

    // Invalidate during fill, during install, and in IDLE with a warm cache.
    access(32'h200, 1'b0, 0, 1'b0, 32'h0, 2);
    access(32'h200, 1'b0, 0, 1'b0, 32'h0, -1);
    access(32'h200, 1'b1, 0, 1'b0, 32'h0, -1);
    access(32'h200, 1'b0, 0, 1'b0, 32'h0, -1);
    access(32'h400, 1'b0, 2, 1'b0, 32'h0, 99);
    access(32'h400, 1'b0, 0, 1'b0, 32'h0, -1);
    access(32'h400, 1'b0, 0, 1'b0, 32'h0, -1);

    // Asynchronous reset in the middle of a refill.
    pc = 32'h300;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("prereset req", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset req", {31'h0, mem_req}, 32'h0);
    chk("async reset addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    access(32'h0, 1'b0, 0, 1'b0, 32'h0, -1);

    // Randomized fetch stream over a small address window to force hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      rp = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      rm = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4);
      access(rp, ($urandom_range(0, 19) == 0), int'($urandom_range(0, 2)),
             ($urandom_range(0, 3) == 0), rm,
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
